// File: rtl/uart_rx_fifo.sv
// uart_rx pin -> 2-flop sync -> 8N1 deframer (8E1 with UART_RX_PARITY_EN) -> DEPTH-entry byte FIFO drained by bus reads.
// Bytes are readable one cycle after the stop-bit sample; a full FIFO drops new bytes and sets overrun.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DEPTH        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    input  logic        ren,
    input  logic [1:0]  address,
    output logic [31:0] data_out,
    output logic        rx_irq
);
    localparam int BW   = $clog2(CLKS_PER_BIT);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int HALF = CLKS_PER_BIT / 2 - 1;
    localparam int FULL = CLKS_PER_BIT - 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state, state_nxt;
    logic            sync1, rxs;
    logic [BW-1:0]   baud_cnt, baud_nxt;
    logic [2:0]      bit_cnt, bit_nxt;
    logic [7:0]      shift, shift_nxt;
    logic            stop_ok, stop_bad;
`ifdef UART_RX_PARITY_EN
    logic            par_bad, par_bad_nxt;
`endif

    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt, count;
    logic            not_empty, full, pop, push, ovr_set, stat_rd;
    logic            overrun, frame_err;
    logic [4:0]      cnt_fld;

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + 1'b1;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = par_bad;
`endif
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (!rxs) state_nxt = START;
            end
            START: begin
                // Resample at mid start bit so later samples land mid-bit
                if (baud_cnt == BW'(HALF)) begin
                    baud_nxt = '0;
                    if (!rxs) begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (baud_cnt == BW'(FULL)) begin
                    baud_nxt           = '0;
                    shift_nxt[bit_cnt] = rxs;
                    bit_nxt            = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_cnt == BW'(FULL)) begin
                    baud_nxt    = '0;
                    par_bad_nxt = rxs ^ (^shift);
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_cnt == BW'(FULL)) begin
                    baud_nxt = '0;
                    if (rxs) begin
                        state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad) stop_bad = 1'b1;
                        else         stop_ok  = 1'b1;
`else
                        stop_ok = 1'b1;
`endif
                    end else begin
                        stop_bad  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                baud_nxt = '0;
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign not_empty = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count     = wr_ptr - rd_ptr;
    assign pop       = ren && (address == 2'd0) && not_empty;
    assign stat_rd   = ren && (address == 2'd1);
    // A same-edge pop frees a slot, so fullness is judged after the pop
    assign push      = stop_ok && (!full || pop);
    assign ovr_set   = stop_ok && full && !pop;
    assign wr_nxt    = wr_ptr + PW'(push);
    assign rd_nxt    = rd_ptr + PW'(pop);
    assign cnt_fld   = (32'(count) > 32'd31) ? 5'd31 : 5'(count);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b1;
            rxs       <= 1'b1;
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rx_irq    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            sync1     <= uart_rx;
            rxs       <= sync1;
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift     <= shift_nxt;
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            overrun   <= ovr_set  | (overrun   & ~stat_rd);
            frame_err <= stop_bad | (frame_err & ~stat_rd);
            rx_irq    <= (wr_nxt != rd_nxt);
`ifdef UART_RX_PARITY_EN
            par_bad   <= par_bad_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr[AW-1:0]] <= shift;
    end

    always_comb begin
        data_out = '0;
        if (!reset) begin
            case (address)
                2'd0:    if (not_empty) data_out = {24'b0, mem[rd_ptr[AW-1:0]]};
                2'd1:    data_out = {16'b0, overrun, frame_err, 1'b0, cnt_fld, 7'b0, not_empty};
                default: data_out = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized frames for uart_rx_fifo, checked against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int C     = 20;
    localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx = 1'b1;
    logic        ren = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [31:0] data_out;
    logic        rx_irq;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  q[$];
    bit          m_ovr = 0;
    bit          m_ferr = 0;
    logic [31:0] popped;
    logic        irq_pre, irq_post;
    logic [31:0] rd;
    logic [7:0]  exp_b;
`ifdef UART_RX_PARITY_EN
    bit          flip_parity = 0;
`endif

    uart_rx_fifo #(.CLKS_PER_BIT(C), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .ren(ren),
        .address(address), .data_out(data_out), .rx_irq(rx_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n = q.size();
        logic [31:0] s = '0;
        s[15]   = m_ovr;
        s[14]   = m_ferr;
        s[12:8] = (n > 31) ? 5'd31 : 5'(n);
        s[0]    = (n != 0);
        return s;
    endfunction

    task automatic m_rx(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovr = 1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        ren = 1'b1;
        address = a;
        #1 d = data_out;
        @(negedge clk);
        ren = 1'b0;
        address = 2'd0;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        read_reg(2'd1, d);
        check(tag, d, exp_status());
        m_ovr = 0;
        m_ferr = 0;
    endtask

    task automatic check_data(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        e = (q.size() != 0) ? {24'b0, q[0]} : 32'd0;
        read_reg(2'd0, d);
        check(tag, d, e);
        if (q.size() != 0) void'(q.pop_front());
    endtask

    // Each bit is held C cycles; the stop sample edge falls 2 + C/2 cycles into the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input bit pop_at_stop);
        logic [NB:0] fb;
        fb       = '0;
        fb[8:1]  = b;
`ifdef UART_RX_PARITY_EN
        fb[9]    = (^b) ^ flip_parity;
`endif
        fb[NB]   = stop_val;
        popped   = '0;
        @(negedge clk);
        for (int i = 0; i <= NB; i++) begin
            uart_rx = fb[i];
            for (int j = 1; j <= C; j++) begin
                @(negedge clk);
                if (i == NB && j == 2 + C / 2) begin
                    irq_pre = rx_irq;
                    if (pop_at_stop) begin
                        ren = 1'b1;
                        address = 2'd0;
                        #1 popped = data_out;
                    end
                end
                if (i == NB && j == 3 + C / 2) begin
                    irq_post = rx_irq;
                    ren = 1'b0;
                end
            end
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        #1 check("rst_data_out", data_out, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_irq", rx_irq, 32'd0);
        reset = 1'b0;
        check_status("rst_status");
        check_data("rst_data_empty");

        // Single byte, irq timing around the stop sample
        send_frame(8'hA5, 1'b1, 1'b0);
        m_rx(8'hA5);
        check("t1_irq_pre", irq_pre, 32'd0);
        check("t1_irq_post", irq_post, 32'd1);
        check("t1_status_lit", exp_status(), 32'h0000_0101);
        check_status("t1_status");
        check_data("t1_data");
        check_status("t1_status_after_pop");
        check("t1_irq_empty", rx_irq, 32'd0);

        // Overflow by one
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            m_rx(8'(i));
        end
        check_status("t2_status_ovr");
        check_status("t2_status_reread");
        for (int i = 0; i < DEPTH; i++) check_data("t2_drain");
        check_data("t2_empty");

        // Framing error followed by a break, then a clean byte
        send_frame(8'h3C, 1'b0, 1'b0);
        uart_rx = 1'b0;
        repeat (20 * C) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        m_ferr = 1;
        send_frame(8'h42, 1'b1, 1'b0);
        m_rx(8'h42);
        check_status("t3_status");
        check_data("t3_data");
        check_data("t3_empty");

        // Glitch shorter than half a bit is rejected
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (C / 4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * C) @(negedge clk);
        check_status("t4_status");
        send_frame(8'h5A, 1'b1, 1'b0);
        m_rx(8'h5A);
        check_data("t4_after_glitch");

        // Full FIFO with a pop on the stop-sample edge
        for (int i = 0; i < DEPTH; i++) begin
            exp_b = 8'($urandom);
            send_frame(exp_b, 1'b1, 1'b0);
            m_rx(exp_b);
        end
        send_frame(8'h77, 1'b1, 1'b1);
        check("t5_popped", popped, {24'b0, q[0]});
        void'(q.pop_front());
        q.push_back(8'h77);
        check_status("t5_status");
        for (int i = 0; i < DEPTH; i++) check_data("t5_drain");

        // Reset in the middle of a frame
        send_frame(8'h33, 1'b1, 1'b0);
        m_rx(8'h33);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (C) @(negedge clk);
        uart_rx = 1'b1;
        repeat (C) @(negedge clk);
        uart_rx = 1'b0;
        repeat (C / 2) @(negedge clk);
        reset = 1'b1;
        uart_rx = 1'b1;
        address = 2'd0;
        #1 check("t6_data_in_reset", data_out, 32'd0);
        repeat (2) @(negedge clk);
        check("t6_irq_in_reset", rx_irq, 32'd0);
        reset = 1'b0;
        q.delete();
        m_ovr = 0;
        m_ferr = 0;
        check_status("t6_status");
        repeat (3) @(negedge clk);
        send_frame(8'h12, 1'b1, 1'b0);
        m_rx(8'h12);
        check_data("t6_data");
        check_status("t6_status_clean");

`ifdef UART_RX_PARITY_EN
        flip_parity = 1;
        send_frame(8'h01, 1'b1, 1'b0);
        flip_parity = 0;
        m_ferr = 1;
        check_status("par_status");
        check_data("par_empty");
`endif

        // Random bytes with random intermittent reads
        for (int i = 0; i < 10; i++) begin
            exp_b = 8'($urandom);
            send_frame(exp_b, 1'b1, 1'b0);
            m_rx(exp_b);
            if ($urandom_range(0, 1) == 1) check_data("rnd_data");
        end
        check_status("rnd_status");
        while (q.size() != 0) check_data("rnd_drain");
        check_data("rnd_empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
